fir_inverse_filter: RTL
=======================

Name: fir_inverse_filter

Overview:
- Recovers the original sample stream x[n] from the output y[n] of a monic FIR filter (h[0] = 1.0), i.e. it is the decoder for the FIR encoder.
- Recursive form: x[n] = y[n] − Σ_{k=1..N-1} h[k]·x[n−k], with history built from its own reconstructed outputs.
- Sits downstream of a fir_filter stage. Streams with valid/ready handshakes.
- Coefficients are runtime-writable through a simple write port.

Parameters:
- N, 8, number of taps including the implicit h[0] = 1.0; N ≥ 2.
- M, 8, bit-width of signed samples and signed coefficients.
- COEF_FRAC, M−2, fractional bits of coefficients (Q format); 1.0 = 2^COEF_FRAC.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  M  signed y[n].
- out_valid  out  1  out_data holds a reconstructed sample.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  M  signed x[n].
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(N)  tap index k; k = 0 and k ≥ N are ignored.
- coef_data  in  M  signed h[k] in Q(COEF_FRAC).
- overflow  out  1  sticky saturation flag (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high):
  - out_valid = 0, out_data = 0, overflow = 0.
  - All history registers x[n−1..n−N+1] = 0.
  - All coefficients h[1..N−1] = 0, so the block is identity passthrough.
  - Reset asserted mid-stream discards any pending output. in_ready reads 1 on the cycle after reset deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Input accept = in_valid && in_ready. Output transfer = out_valid && out_ready.
- Latency:
  - A sample accepted at edge t appears on out_data with out_valid = 1 after edge t (1 cycle).
  - Full throughput is 1 sample/cycle while out_ready = 1.
- Stall:
  - While out_valid && !out_ready: out_data, out_valid and history hold, and in_ready = 0.
  - No sample is lost or duplicated.
- No accept and the output transferred: out_valid drops to 0 and out_data holds its last value.
- Arithmetic:
  - acc = Σ_{k=1..N-1} h[k]·x[n−k], full precision, width 2M + $clog2(N).
  - fb = acc >>> COEF_FRAC (arithmetic shift, truncates toward −inf).
  - r = sign-extended in_data − fb, at full width.
  - x[n] = r reduced to M bits per the Optional Feature.
- History:
  - On accept, shift in the reduced x[n] (the same value driven on out_data), so history always equals the emitted stream.
  - Oldest entry drops out.
- Coefficient writes:
  - coef_we at edge t updates h[coef_addr] at edge t; writes are accepted regardless of stream state.
  - Write and input accept in the same cycle: the computation uses the old coefficient; the new value applies from the next accepted sample.
  - Writes do not clear history.
- Structure: a single datapath stage; no FSM beyond the output valid register. The MAC may be a combinational sum.

Optional Feature:
- Macro: FIR_INV_SAT_EN.
- Defined:
  - r is saturated to [−2^(M−1), 2^(M−1)−1].
  - overflow sets to 1 on any accepted sample where clipping occurred and stays set until reset.
- Undefined:
  - r is truncated to its low M bits (two's-complement wrap).
  - overflow is tied to 0.

Test Plan (N=4, M=8, COEF_FRAC=6, out_ready=1 unless stated):
1. Passthrough: after reset, send 5, −3, 127, −128 back-to-back → out_data 5, −3, 127, −128, each one cycle after accept; out_valid continuous.
2. Deconvolution: write h[1] = 32 (0.5), then send 64, 32, 0, 0 (the FIR output of x = 64, 0, 0, 0) → outputs 64, 0, 0, 0.
3. Backpressure: hold in_valid = 1 with in_data = 10, 20, 30, and drop out_ready for 3 cycles after the first output → in_ready = 0 and out_data holds 10 during the stall; the sequence 10, 20, 30 is delivered exactly once.
4. Saturation: write h[1] = −64 (−1.0), send 100, 100, 0 →
   - with FIR_INV_SAT_EN: 100, 127, 127, and overflow = 1 from the second sample onward;
   - without it: 100, −56, −56, and overflow = 0.
5. Coefficient-write race: accept 64 and then 64 with h[1] = 0 while writing h[1] = 64 in the same cycle as the second accept → outputs 64, 64. A third input of 0 → −64.
6. Mid-stream reset: stream 3 samples with h[1] = 32, assert reset for 1 cycle with in_valid high → out_valid = 0 and overflow = 0 after the reset edge; the next sample of 40 outputs 40 (history and coefficients cleared).

Source files
------------

// File: rtl/fir_inverse_filter.sv
// Recursive inverse of a monic FIR: x[n] = y[n] - sum_{k>=1} h[k]*x[n-k], one registered stage.
// Define FIR_INV_SAT_EN to saturate x[n] and raise a sticky overflow flag; otherwise x[n] wraps.
module fir_inverse_filter #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int COEF_FRAC = M - 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [M-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M-1:0]         out_data,
  input  logic                 coef_we,
  input  logic [$clog2(N)-1:0] coef_addr,
  input  logic [M-1:0]         coef_data,
  output logic                 overflow
);
  localparam int AW   = $clog2(N);
  localparam int PW   = 2 * M;
  localparam int ACCW = 2 * M + $clog2(N);

  logic [M-1:0]           coef_reg [1:N-1];
  logic [M-1:0]           hist_reg [1:N-1];
  logic [PW-1:0]          prod     [1:N-1];
  logic [M-1:0]           out_data_reg;
  logic                   out_valid_reg;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] fb;
  logic signed [ACCW-1:0] r;
  logic [M-1:0]           x_next;
  logic                   accept;

  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // Operands sign-extended to the product width, so a plain modular multiply gives the signed product.
  genvar gi;
  generate
    for (gi = 1; gi < N; gi++) begin : g_tap
      assign prod[gi] = {{M{coef_reg[gi][M-1]}}, coef_reg[gi]} *
                        {{M{hist_reg[gi][M-1]}}, hist_reg[gi]};
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int k = 1; k < N; k++) begin
      acc = acc + $signed({{(ACCW-PW){prod[k][PW-1]}}, prod[k]});
    end
    fb = acc >>> COEF_FRAC;
    r  = $signed({{(ACCW-M){in_data[M-1]}}, in_data}) - fb;
  end

`ifdef FIR_INV_SAT_EN
  logic clip;
  logic overflow_reg;

  // r fits in M bits only when all bits from M-1 upward agree with the sign.
  assign clip   = !((&r[ACCW-1:M-1]) || !(|r[ACCW-1:M-1]));
  assign x_next = clip ? (r[ACCW-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}})
                       : r[M-1:0];
  assign overflow = overflow_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (accept && clip) begin
      overflow_reg <= 1'b1;
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^r[ACCW-1:M];
  assign x_next    = r[M-1:0];
  assign overflow  = 1'b0;
`endif

  // Coefficient writes land regardless of stream state; a same-cycle accept still saw the old value.
  always_ff @(posedge clk) begin
    for (int k = 1; k < N; k++) begin
      if (reset) begin
        coef_reg[k] <= '0;
      end else if (coef_we && coef_addr == AW'(k)) begin
        coef_reg[k] <= coef_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 1; k < N; k++) begin
      if (reset) begin
        hist_reg[k] <= '0;
      end else if (accept) begin
        hist_reg[k] <= (k == 1) ? x_next : hist_reg[(k > 1) ? k - 1 : 1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= x_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end
endmodule
